// File: rtl/fpu_multicycle_ctrl.sv
// Issue-side sequencer for the multi-cycle FP sub-units: one op in flight, a start pulse
// to the selected unit, and a one-entry result buffer drained through a valid/ready port.
module fpu_multicycle_ctrl #(
    parameter int NUM_UNITS   = 4,
    parameter int RESULT_W    = 64,
    parameter int TIMEOUT_CYC = 64,
    // Widen beyond $clog2(NUM_UNITS) to let the issue path present out-of-range indices.
    parameter int UNIT_W      = $clog2(NUM_UNITS)
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_req_valid,
    output logic                          o_req_ready,
    input  logic [UNIT_W-1:0]             i_req_unit,
    input  logic [4:0]                    i_req_rd,
    input  logic                          i_req_int_dest,
    input  logic                          i_flush,
    output logic [NUM_UNITS-1:0]          o_unit_start,
    input  logic [NUM_UNITS-1:0]          i_unit_valid,
    input  logic [NUM_UNITS*RESULT_W-1:0] i_unit_result,
    input  logic [NUM_UNITS*5-1:0]        i_unit_fflags,
    output logic                          o_wb_valid,
    input  logic                          i_wb_ready,
    output logic [RESULT_W-1:0]           o_wb_result,
    output logic [4:0]                    o_wb_rd,
    output logic                          o_wb_int_dest,
    output logic [4:0]                    o_wb_fflags,
    output logic                          o_busy,
    output logic                          o_timeout
);

    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0]    CNT_MAX  = CNT_W'(TIMEOUT_CYC);
    localparam logic [RESULT_W-1:0] INT_MASK = {{(RESULT_W-32){1'b0}}, {32{1'b1}}};
    localparam logic [4:0]          FLAG_NV  = 5'b10000;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DRAIN = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic [UNIT_W-1:0]     unit_q, unit_d;
    logic [4:0]            rd_q, rd_d;
    logic                  int_dest_q, int_dest_d;
    logic [RESULT_W-1:0]   result_q, result_d;
    logic [4:0]            fflags_q, fflags_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_UNITS-1:0]  start_q, start_d;
    logic                  timeout_q, timeout_d;
    logic                  wb_valid_q, wb_valid_d;

    logic                  accept_s;
    logic                  req_in_range_s;
    logic                  sel_valid_s;
    logic [RESULT_W-1:0]   sel_result_s;
    logic [4:0]            sel_fflags_s;
    logic [CNT_W-1:0]      cnt_inc_s;
    logic                  timeout_hit_s;

    function automatic logic unit_in_range(input logic [UNIT_W-1:0] unit);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            hit = hit | (unit == UNIT_W'(k));
        end
        return hit;
    endfunction

    // Steer the latched unit's valid/result/flags; every other unit is invisible.
    always_comb begin
        sel_valid_s  = 1'b0;
        sel_result_s = {RESULT_W{1'b0}};
        sel_fflags_s = 5'b00000;
        for (int k = 0; k < NUM_UNITS; k++) begin
            sel_valid_s  = sel_valid_s  | ((unit_q == UNIT_W'(k)) & i_unit_valid[k]);
            sel_result_s = sel_result_s | ({RESULT_W{unit_q == UNIT_W'(k)}} &
                                           i_unit_result[k*RESULT_W +: RESULT_W]);
            sel_fflags_s = sel_fflags_s | ({5{unit_q == UNIT_W'(k)}} & i_unit_fflags[k*5 +: 5]);
        end
    end

    assign o_req_ready    = !i_flush && ((state_q == S_IDLE) || ((state_q == S_HOLD) && i_wb_ready));
    assign accept_s       = i_req_valid && o_req_ready;
    assign req_in_range_s = unit_in_range(i_req_unit);
    assign cnt_inc_s      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    assign timeout_hit_s  = (TIMEOUT_CYC != 0) && (cnt_inc_s == CNT_MAX);

    // Next-state, buffer and timeout-counter logic.
    always_comb begin
        state_d    = state_q;
        unit_d     = unit_q;
        rd_d       = rd_q;
        int_dest_d = int_dest_q;
        result_d   = result_q;
        fflags_d   = fflags_q;
        cnt_d      = cnt_q;
        timeout_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = {CNT_W{1'b0}};
            end
            S_START: begin
                // The pulse is already on the wire; a flush can only make us discard the answer.
                cnt_d   = {CNT_W{1'b0}};
                state_d = i_flush ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                if (sel_valid_s) begin
                    if (i_flush) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d  = S_HOLD;
                        result_d = int_dest_q ? (sel_result_s & INT_MASK) : sel_result_s;
                        fflags_d = sel_fflags_s;
                    end
                end else if (timeout_hit_s) begin
                    cnt_d     = cnt_inc_s;
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d   = cnt_inc_s;
                    state_d = i_flush ? S_DRAIN : S_WAIT;
                end
            end
            S_HOLD: begin
                if (i_flush || i_wb_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_DRAIN: begin
                if (sel_valid_s) begin
                    state_d = S_IDLE;
                end else if (timeout_hit_s) begin
                    cnt_d     = cnt_inc_s;
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // An accept in HOLD overrides the drain-to-IDLE decision above (back-to-back issue).
        if (accept_s) begin
            unit_d     = i_req_unit;
            rd_d       = i_req_rd;
            int_dest_d = i_req_int_dest;
            cnt_d      = {CNT_W{1'b0}};
            if (req_in_range_s) begin
                state_d = S_START;
            end else begin
                state_d  = S_HOLD;
                result_d = {RESULT_W{1'b0}};
                fflags_d = FLAG_NV;
            end
        end else begin
            unit_d = unit_d;
        end
    end

    // Registered start pulse and writeback-valid derived from the next state.
    always_comb begin
        for (int k = 0; k < NUM_UNITS; k++) begin
            start_d[k] = (state_d == S_START) && (unit_d == UNIT_W'(k));
        end
        wb_valid_d = (state_d == S_HOLD);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            unit_q     <= {UNIT_W{1'b0}};
            rd_q       <= 5'd0;
            int_dest_q <= 1'b0;
            result_q   <= {RESULT_W{1'b0}};
            fflags_q   <= 5'b00000;
            cnt_q      <= {CNT_W{1'b0}};
            start_q    <= {NUM_UNITS{1'b0}};
            timeout_q  <= 1'b0;
            wb_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            unit_q     <= unit_d;
            rd_q       <= rd_d;
            int_dest_q <= int_dest_d;
            result_q   <= result_d;
            fflags_q   <= fflags_d;
            cnt_q      <= cnt_d;
            start_q    <= start_d;
            timeout_q  <= timeout_d;
            wb_valid_q <= wb_valid_d;
        end
    end

    assign o_unit_start  = start_q;
    assign o_wb_valid    = wb_valid_q;
    assign o_wb_result   = result_q;
    assign o_wb_rd       = rd_q;
    assign o_wb_int_dest = int_dest_q;
    assign o_wb_fflags   = fflags_q;
    assign o_busy        = (state_q != S_IDLE);
    assign o_timeout     = timeout_q;

endmodule

// File: tb/tb_fpu_multicycle_ctrl.sv
// Bench for fpu_multicycle_ctrl: behavioural sub-unit responders, a writeback scoreboard,
// a vector table for single ops and hand sequences for flush/timeout/reset corners.
module tb_fpu_multicycle_ctrl;

    localparam int NU = 4;
    localparam int RW = 64;

    logic           i_clk, i_rst, i_req_valid, o_req_ready, i_req_int_dest, i_flush;
    logic [2:0]     i_req_unit;
    logic [4:0]     i_req_rd;
    logic [NU-1:0]  o_unit_start, i_unit_valid;
    logic [NU*RW-1:0] i_unit_result;
    logic [NU*5-1:0]  i_unit_fflags;
    logic           o_wb_valid, i_wb_ready, o_wb_int_dest, o_busy, o_timeout;
    logic [RW-1:0]  o_wb_result;
    logic [4:0]     o_wb_rd, o_wb_fflags;

    fpu_multicycle_ctrl #(.NUM_UNITS(NU), .RESULT_W(RW), .TIMEOUT_CYC(8), .UNIT_W(3)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_unit(i_req_unit), .i_req_rd(i_req_rd), .i_req_int_dest(i_req_int_dest),
        .i_flush(i_flush), .o_unit_start(o_unit_start), .i_unit_valid(i_unit_valid),
        .i_unit_result(i_unit_result), .i_unit_fflags(i_unit_fflags), .o_wb_valid(o_wb_valid),
        .i_wb_ready(i_wb_ready), .o_wb_result(o_wb_result), .o_wb_rd(o_wb_rd),
        .o_wb_int_dest(o_wb_int_dest), .o_wb_fflags(o_wb_fflags), .o_busy(o_busy),
        .o_timeout(o_timeout)
    );

    typedef struct {
        logic [2:0]  unit;
        logic [4:0]  rd;
        logic        int_dest;
        logic [63:0] res;
        logic [4:0]  flg;
        int          lat;
        logic [3:0]  noise;
        logic [63:0] exp_res;
        logic [4:0]  exp_flg;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic        int_dest;
        logic [63:0] res;
        logic [4:0]  flg;
    } wb_t;

    vec_t        vt[6];
    wb_t         exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          lat[NU];
    int          cd[NU];
    logic [63:0] cur_res[NU];
    logic [4:0]  cur_flg[NU];
    logic [3:0]  noise_v;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Sub-unit model: a start seen in cycle S yields a one-cycle valid in cycle S+lat; lat 0 = silent.
    initial begin
        i_unit_valid  = '0;
        i_unit_result = '0;
        i_unit_fflags = '0;
        for (int k = 0; k < NU; k++) cd[k] = 0;
        forever begin
            logic [NU-1:0] fire;
            @(posedge i_clk);
            #1;
            fire = '0;
            for (int k = 0; k < NU; k++) begin
                if (cd[k] > 0) begin
                    cd[k] = cd[k] - 1;
                    if (cd[k] == 0) fire[k] = 1'b1;
                end
                if (o_unit_start[k]) cd[k] = lat[k];
                i_unit_result[k*RW +: RW] = cur_res[k];
                i_unit_fflags[k*5 +: 5]   = cur_flg[k];
            end
            i_unit_valid = fire | noise_v;
        end
    end

    // Writeback monitor: every handshake must match the oldest expected result.
    initial begin
        forever begin
            wb_t e;
            @(posedge i_clk);
            #3;
            if (!i_rst && !i_flush && o_wb_valid && i_wb_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL wb_unexpected: got result 0x%0h rd %0d, expected no writeback",
                             o_wb_result, o_wb_rd);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_result", o_wb_result, e.res);
                    chk("wb_rd", 64'(o_wb_rd), 64'(e.rd));
                    chk("wb_int_dest", 64'(o_wb_int_dest), 64'(e.int_dest));
                    chk("wb_fflags", 64'(o_wb_fflags), 64'(e.flg));
                end
            end
        end
    end

    task automatic issue(input logic [2:0] unit, input logic [4:0] rd, input logic int_dest);
        i_req_valid    = 1'b1;
        i_req_unit     = unit;
        i_req_rd       = rd;
        i_req_int_dest = int_dest;
    endtask

    task automatic expect_wb(input logic [4:0] rd, input logic id, input logic [63:0] r,
                             input logic [4:0] f);
        wb_t e;
        e.rd = rd; e.int_dest = id; e.res = r; e.flg = f;
        exp_q.push_back(e);
    endtask

    task automatic wait_wb(output int n);
        n = 1;
        while (!o_wb_valid && n < 40) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n;
        logic [3:0] exp_start;

        vt[0] = '{3'd0, 5'd7,  1'b1, 64'h10,                  5'b00000, 1, 4'b0000, 64'h10,                  5'b00000};
        vt[1] = '{3'd1, 5'd3,  1'b0, 64'h4000_0000_0000_0000, 5'b00001, 3, 4'b1101, 64'h4000_0000_0000_0000, 5'b00001};
        vt[2] = '{3'd2, 5'd31, 1'b1, 64'hDEAD_BEEF_0000_0001, 5'b00000, 2, 4'b0000, 64'h0000_0000_0000_0001, 5'b00000};
        vt[3] = '{3'd3, 5'd0,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 5'b11111, 5, 4'b0111, 64'hFFFF_FFFF_FFFF_FFFF, 5'b11111};
        vt[4] = '{3'd5, 5'd9,  1'b0, 64'h0,                   5'b00000, 0, 4'b0000, 64'h0,                   5'b10000};
        vt[5] = '{3'd7, 5'd12, 1'b1, 64'h0,                   5'b00000, 0, 4'b0000, 64'h0,                   5'b10000};

        for (int k = 0; k < NU; k++) begin
            lat[k] = 1; cur_res[k] = 64'h0; cur_flg[k] = 5'b00000;
        end
        noise_v = 4'b0000;
        i_rst = 1'b1; i_req_valid = 1'b0; i_req_unit = 3'd0; i_req_rd = 5'd0;
        i_req_int_dest = 1'b0; i_flush = 1'b0; i_wb_ready = 1'b0;

        // Reset state
        step(); step();
        chk("rst_req_ready", 64'(o_req_ready), 64'd1);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_wb_valid", 64'(o_wb_valid), 64'd0);
        chk("rst_unit_start", 64'(o_unit_start), 64'd0);
        chk("rst_timeout", 64'(o_timeout), 64'd0);
        chk("rst_wb_result", o_wb_result, 64'd0);
        i_rst = 1'b0;
        step();

        // Vector table: isolated ops, latency and start decode
        for (int i = 0; i < 6; i++) begin
            if (vt[i].unit < 3'd4) begin
                cur_res[vt[i].unit[1:0]] = vt[i].res;
                cur_flg[vt[i].unit[1:0]] = vt[i].flg;
                lat[vt[i].unit[1:0]]     = vt[i].lat;
                exp_start = 4'b0001 << vt[i].unit[1:0];
            end else begin
                exp_start = 4'b0000;
            end
            noise_v    = vt[i].noise;
            i_wb_ready = 1'b1;
            issue(vt[i].unit, vt[i].rd, vt[i].int_dest);
            #1;
            chk("vec_req_ready", 64'(o_req_ready), 64'd1);
            expect_wb(vt[i].rd, vt[i].int_dest, vt[i].exp_res, vt[i].exp_flg);
            step();
            i_req_valid = 1'b0;
            chk("vec_unit_start", 64'(o_unit_start), 64'(exp_start));
            chk("vec_busy", 64'(o_busy), 64'd1);
            wait_wb(n);
            chk("vec_latency", 64'(n), (vt[i].unit < 3'd4) ? 64'(2 + vt[i].lat) : 64'd1);
            step();
            chk("vec_idle", 64'(o_busy), 64'd0);
            noise_v = 4'b0000;
        end

        // Back-to-back: second request accepted in the HOLD handshake cycle
        cur_res[0] = 64'hA;                  cur_flg[0] = 5'b00000; lat[0] = 1;
        cur_res[1] = 64'h3FF0_0000_0000_0000; cur_flg[1] = 5'b00010; lat[1] = 2;
        i_wb_ready = 1'b1;
        issue(3'd0, 5'd1, 1'b0);
        expect_wb(5'd1, 1'b0, 64'hA, 5'b00000);
        step();
        i_req_valid = 1'b0;
        chk("b2b_start0", 64'(o_unit_start), 64'b0001);
        step(); step();
        chk("b2b_hold0", 64'(o_wb_valid), 64'd1);
        issue(3'd1, 5'd2, 1'b0);
        #1;
        chk("b2b_req_ready", 64'(o_req_ready), 64'd1);
        expect_wb(5'd2, 1'b0, 64'h3FF0_0000_0000_0000, 5'b00010);
        step();
        i_req_valid = 1'b0;
        chk("b2b_start1", 64'(o_unit_start), 64'b0010);
        chk("b2b_no_dup", 64'(o_wb_valid), 64'd0);
        wait_wb(n);
        chk("b2b_latency", 64'(n), 64'd4);
        step();
        chk("b2b_idle", 64'(o_busy), 64'd0);

        // Writeback backpressure: buffer stable for 5 cycles
        cur_res[2] = 64'h1234_5678_9ABC_DEF0; cur_flg[2] = 5'b00100; lat[2] = 1;
        i_wb_ready = 1'b0;
        issue(3'd2, 5'd17, 1'b0);
        expect_wb(5'd17, 1'b0, 64'h1234_5678_9ABC_DEF0, 5'b00100);
        step();
        i_req_valid = 1'b0;
        wait_wb(n);
        chk("bp_latency", 64'(n), 64'd3);
        for (int j = 0; j < 5; j++) begin
            chk("bp_result", o_wb_result, 64'h1234_5678_9ABC_DEF0);
            chk("bp_rd", 64'(o_wb_rd), 64'd17);
            chk("bp_busy", 64'(o_busy), 64'd1);
            chk("bp_req_ready", 64'(o_req_ready), 64'd0);
            step();
        end
        i_wb_ready = 1'b1;
        step();
        chk("bp_idle", 64'(o_busy), 64'd0);

        // Flush in IDLE blocks the same-cycle request
        issue(3'd0, 5'd5, 1'b0);
        i_flush = 1'b1;
        #1;
        chk("fl_idle_ready", 64'(o_req_ready), 64'd0);
        step();
        i_flush = 1'b0; i_req_valid = 1'b0;
        chk("fl_idle_busy", 64'(o_busy), 64'd0);

        // Flush in WAIT, unit answers 3 cycles later with 0x200
        cur_res[3] = 64'h200; lat[3] = 4;
        issue(3'd3, 5'd4, 1'b0);
        step();
        i_req_valid = 1'b0;
        step();
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        for (int j = 0; j < 3; j++) begin
            chk("fl_wait_drain_busy", 64'(o_busy), 64'd1);
            chk("fl_wait_no_wb", 64'(o_wb_valid), 64'd0);
            step();
        end
        chk("fl_wait_idle", 64'(o_busy), 64'd0);
        chk("fl_wait_ready", 64'(o_req_ready), 64'd1);

        // Flush in START: pulse still issued, result discarded
        lat[0] = 2;
        issue(3'd0, 5'd6, 1'b0);
        step();
        i_req_valid = 1'b0;
        i_flush = 1'b1;
        chk("fl_start_pulse", 64'(o_unit_start), 64'b0001);
        step();
        i_flush = 1'b0;
        chk("fl_start_drain", 64'(o_busy), 64'd1);
        step(); step();
        chk("fl_start_idle", 64'(o_busy), 64'd0);
        chk("fl_start_no_wb", 64'(o_wb_valid), 64'd0);

        // Flush in HOLD drops the buffer
        lat[2] = 1;
        i_wb_ready = 1'b0;
        issue(3'd2, 5'd8, 1'b0);
        step();
        i_req_valid = 1'b0;
        wait_wb(n);
        chk("fl_hold_latency", 64'(n), 64'd3);
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        chk("fl_hold_wb_valid", 64'(o_wb_valid), 64'd0);
        chk("fl_hold_idle", 64'(o_busy), 64'd0);
        i_wb_ready = 1'b1;

        // Timeout: silent unit, 8 WAIT cycles then a single pulse
        lat[1] = 0;
        issue(3'd1, 5'd10, 1'b0);
        step();
        i_req_valid = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            chk("to_pulse", 64'(o_timeout), (k == 10) ? 64'd1 : 64'd0);
            if (k == 9) chk("to_busy_before", 64'(o_busy), 64'd1);
            if (k == 10) begin
                chk("to_idle", 64'(o_busy), 64'd0);
                chk("to_ready", 64'(o_req_ready), 64'd1);
                chk("to_no_wb", 64'(o_wb_valid), 64'd0);
            end
            step();
        end

        // Reset during WAIT: no start re-issue, late valid ignored
        lat[2] = 3;
        issue(3'd2, 5'd11, 1'b0);
        step();
        i_req_valid = 1'b0;
        step();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        chk("rst_mid_ready", 64'(o_req_ready), 64'd1);
        for (int j = 0; j < 4; j++) begin
            chk("rst_mid_busy", 64'(o_busy), 64'd0);
            chk("rst_mid_start", 64'(o_unit_start), 64'd0);
            chk("rst_mid_wb", 64'(o_wb_valid), 64'd0);
            step();
        end

        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
